// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - splits a register request into pointer + data master transactions
// Drives i2c_master_top start/addr/data/rw, tracks busy, reports completion or error.
module i2c_reg_sequencer #(
    parameter int unsigned START_PULSE    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic [7:0] m_data,
    output logic       m_rw,
    input  logic       m_busy,
    input  logic [7:0] m_rdata,
    input  logic       m_nack
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PTR_START   = 3'd1,
        PTR_WAIT_HI = 3'd2,
        PTR_WAIT_LO = 3'd3,
        DAT_START   = 3'd4,
        DAT_WAIT_HI = 3'd5,
        DAT_WAIT_LO = 3'd6,
        RESP        = 3'd7
    } state_t;

    localparam logic [15:0] PULSE_LAST  = 16'(START_PULSE - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_NACK    = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_qq, nack_q;
    logic [7:0]  rdata_in_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [6:0]  m_addr_q;
    logic [7:0]  m_data_q;
    logic        m_rw_q;
    logic [7:0]  rsp_rdata_q;
    logic [1:0]  rsp_err_q;
    logic        busy_fall;
    logic        timed_out;

    // Master status is registered once, so a fall is seen one cycle late and
    // nack/rdata are taken from the same registered sample as the fall.
    assign busy_fall = busy_qq & ~busy_q;
    assign timed_out = (cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (req_valid) state_d = PTR_START;
            PTR_START:   if (cnt_q == PULSE_LAST) state_d = PTR_WAIT_HI;
            PTR_WAIT_HI: begin
                if (busy_q)         state_d = PTR_WAIT_LO;
                else if (timed_out) state_d = RESP;
            end
            PTR_WAIT_LO: begin
                if (busy_fall)      state_d = nack_q ? RESP : DAT_START;
                else if (timed_out) state_d = RESP;
            end
            DAT_START:   if (cnt_q == PULSE_LAST) state_d = DAT_WAIT_HI;
            DAT_WAIT_HI: begin
                if (busy_q)         state_d = DAT_WAIT_LO;
                else if (timed_out) state_d = RESP;
            end
            DAT_WAIT_LO: if (busy_fall || timed_out) state_d = RESP;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        cnt_d = (state_q == IDLE || state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        m_start   = (state_q == PTR_START) || (state_q == DAT_START);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q      <= 1'b0;
            busy_qq     <= 1'b0;
            nack_q      <= 1'b0;
            rdata_in_q  <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_rw_q      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            busy_q     <= m_busy;
            busy_qq    <= busy_q;
            nack_q     <= m_nack;
            rdata_in_q <= m_rdata;
            if (state_q == IDLE && req_valid) begin
                rw_q     <= req_rw;
                wdata_q  <= req_wdata;
                m_addr_q <= req_dev_addr;
                m_data_q <= req_reg_addr;
                m_rw_q   <= 1'b0;
            end
            // A read keeps the pointer byte on m_data during the data phase.
            if (state_q == PTR_WAIT_LO && state_d == DAT_START) begin
                m_data_q <= rw_q ? m_data_q : wdata_q;
                m_rw_q   <= rw_q;
            end
            if (state_q != RESP && state_d == RESP) begin
                if (busy_fall && (state_q == PTR_WAIT_LO || state_q == DAT_WAIT_LO)) begin
                    rsp_err_q <= nack_q ? ERR_NACK : ERR_OK;
                    if (!nack_q && rw_q && state_q == DAT_WAIT_LO) rsp_rdata_q <= rdata_in_q;
                end else begin
                    rsp_err_q <= ERR_TIMEOUT;
                end
            end
        end
    end

    assign m_addr    = m_addr_q;
    assign m_data    = m_data_q;
    assign m_rw      = m_rw_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - scoreboard bench for i2c_reg_sequencer
module tb_i2c_reg_sequencer;

    localparam int SP   = 8;
    localparam int TMO2 = 64;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
        logic       rw;
    } pulse_t;

    typedef struct packed {
        logic [1:0] err;
        logic [7:0] rdata;
        logic       lat;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       m_start, m_rw, m_busy, m_nack;
    logic [6:0] m_addr;
    logic [7:0] m_data, m_rdata;

    logic       t_req_valid, t_req_ready;
    logic       t_rsp_valid;
    logic [7:0] t_rsp_rdata;
    logic [1:0] t_rsp_err;
    logic       t_m_start, t_m_rw;
    logic [6:0] t_m_addr;
    logic [7:0] t_m_data;
    logic       t_m_busy  = 1'b0;
    logic       t_m_nack  = 1'b0;
    logic [7:0] t_m_rdata = 8'h00;

    i2c_reg_sequencer #(.START_PULSE(SP), .TIMEOUT_CYCLES(4096)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
        .m_busy(m_busy), .m_rdata(m_rdata), .m_nack(m_nack)
    );

    i2c_reg_sequencer #(.START_PULSE(SP), .TIMEOUT_CYCLES(TMO2)) u_tmo (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_rw(1'b0),
        .req_dev_addr(7'h02), .req_reg_addr(8'h2F), .req_wdata(8'hA5),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
        .m_start(t_m_start), .m_addr(t_m_addr), .m_data(t_m_data), .m_rw(t_m_rw),
        .m_busy(t_m_busy), .m_rdata(t_m_rdata), .m_nack(t_m_nack)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_t pulse_q[$];
    rsp_t   rsp_q[$];
    rsp_t   t_rsp_q[$];
    logic [7:0] exp_rdata = 8'h00;

    int         busy_len  = 200;
    bit         nack_ptr  = 1'b0;
    logic [7:0] rd_val    = 8'h00;
    int         phase_idx = 0;
    int         fall_cyc  = 0;
    int         rsp_seen_cyc = -10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Master model: busy rises shortly after each start pulse, falls after busy_len cycles.
    initial begin
        m_busy = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (m_start && reset) begin
                for (int k = 0; k < 1000 && m_start; k++) @(negedge clk);
                phase_idx++;
                repeat (2) @(negedge clk);
                m_nack = 1'b0;
                m_busy = 1'b1;
                repeat (busy_len - 1) @(negedge clk);
                m_rdata  = rd_val;
                m_nack   = nack_ptr && (phase_idx == 1);
                m_busy   = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Monitor for the main instance: start pulses and responses.
    initial begin
        bit     start_prev;
        bit     rsp_prev;
        int     width;
        pulse_t cur, pe;
        rsp_t   re;
        start_prev = 1'b0; rsp_prev = 1'b0; width = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                start_prev = 1'b0; rsp_prev = 1'b0;
            end else begin
                if (rsp_prev) chk("ready_after_rsp", req_ready, 1);
                if (m_start) begin
                    if (!start_prev) begin
                        width = 0;
                        cur = '{addr: m_addr, data: m_data, rw: m_rw};
                    end
                    width++;
                end else if (start_prev) begin
                    if (pulse_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse: got data 0x%0h rw %0d, expected none", cur.data, cur.rw);
                    end else begin
                        pe = pulse_q.pop_front();
                        chk("pulse_width", width, SP);
                        chk("pulse_addr", cur.addr, pe.addr);
                        chk("pulse_data", cur.data, pe.data);
                        chk("pulse_rw", cur.rw, pe.rw);
                    end
                end
                if (rsp_valid) begin
                    rsp_seen_cyc = cyc;
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got err %0d, expected no response", rsp_err);
                    end else begin
                        re = rsp_q.pop_front();
                        chk("rsp_err", rsp_err, re.err);
                        chk("rsp_rdata", rsp_rdata, re.rdata);
                        if (re.lat) chk("rsp_latency", cyc - fall_cyc, 2);
                    end
                end
                start_prev = m_start;
                rsp_prev   = rsp_valid;
            end
        end
    end

    // Monitor for the short-timeout instance.
    initial begin
        bit   t_prev;
        int   wait_hi_cyc, t_pulses;
        rsp_t re;
        t_prev = 1'b0; wait_hi_cyc = 0; t_pulses = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (t_m_start && !t_prev) t_pulses++;
                if (!t_m_start && t_prev) wait_hi_cyc = cyc;
                if (t_rsp_valid) begin
                    if (t_rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_tmo_rsp: got err %0d, expected none", t_rsp_err);
                    end else begin
                        re = t_rsp_q.pop_front();
                        chk("tmo_err", t_rsp_err, re.err);
                        chk("tmo_rdata", t_rsp_rdata, re.rdata);
                        chk("tmo_latency", cyc - wait_hi_cyc, TMO2);
                        chk("tmo_pulses", t_pulses, 1);
                    end
                end
                t_prev = t_m_start;
            end
        end
    end

    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rd, input logic [1:0] err,
                         input bit two_phase, input bit want_rsp, output int acc_cyc);
        bit ok;
        pulse_q.push_back('{addr: dev, data: rg, rw: 1'b0});
        if (two_phase) pulse_q.push_back('{addr: dev, data: (rw ? rg : wd), rw: rw});
        if (want_rsp) begin
            if (err == 2'b00 && rw) exp_rdata = rd;
            rsp_q.push_back('{err: err, rdata: exp_rdata, lat: 1'b1});
        end
        req_valid = 1'b1; req_rw = rw; req_dev_addr = dev; req_reg_addr = rg; req_wdata = wd;
        ok = 1'b0;
        acc_cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            if (req_ready) begin ok = 1'b1; acc_cyc = cyc; break; end
            @(negedge clk);
        end
        chk("accept_seen", ok, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ready_drops", req_ready, 0);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (rsp_q.size() == 0 && pulse_q.size() == 0 && t_rsp_q.size() == 0) begin
                done = 1'b1; break;
            end
            @(negedge clk);
        end
        chk("drain_in_time", done, 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        reset = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
        t_req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_rw", m_rw, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // register write
        phase_idx = 0; nack_ptr = 0; rd_val = 8'h00;
        issue(1'b0, 7'h02, 8'h2F, 8'hA5, 8'h00, 2'b00, 1'b1, 1'b1, acc);
        wait_done();

        // register read
        phase_idx = 0; rd_val = 8'h3C;
        issue(1'b1, 7'h02, 8'h2F, 8'h00, 8'h3C, 2'b00, 1'b1, 1'b1, acc);
        wait_done();

        // pointer-phase NACK: single pulse, rdata kept
        phase_idx = 0; nack_ptr = 1; rd_val = 8'hEE;
        issue(1'b1, 7'h02, 8'h2F, 8'h00, 8'hEE, 2'b01, 1'b0, 1'b1, acc);
        wait_done();
        nack_ptr = 0;

        // timeout on the short-timeout instance, master never busy
        t_rsp_q.push_back('{err: 2'b10, rdata: 8'h00, lat: 1'b0});
        t_req_valid = 1'b1;
        @(negedge clk);
        t_req_valid = 1'b0;
        wait_done();

        // back-to-back with an ignored mid-transaction request
        phase_idx = 0; rd_val = 8'h5A;
        issue(1'b0, 7'h11, 8'h10, 8'h77, 8'h00, 2'b00, 1'b1, 1'b1, acc);
        repeat (50) @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_dev_addr = 7'h55; req_reg_addr = 8'hEE;
        chk("busy_not_ready", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0;
        issue(1'b1, 7'h22, 8'h40, 8'h00, 8'h5A, 2'b00, 1'b1, 1'b1, acc);
        chk("b2b_accept_cycle", acc, rsp_seen_cyc + 1);
        wait_done();

        // reset during data-phase busy: no response for the aborted write
        phase_idx = 0; rd_val = 8'h00;
        issue(1'b0, 7'h33, 8'h01, 8'h99, 8'h00, 2'b00, 1'b1, 1'b0, acc);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (pulse_q.size() == 0 && m_busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("reached_dat_wait_lo", ok, 1);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_m_start", m_start, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        exp_rdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);

        // recovery after reset
        phase_idx = 0; rd_val = 8'hC3;
        issue(1'b1, 7'h7F, 8'h00, 8'h00, 8'hC3, 2'b00, 1'b1, 1'b1, acc);
        wait_done();

        chk("queues_empty", rsp_q.size() + pulse_q.size() + t_rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
